rc_channel_arbiter: RTL and testbench
=====================================

Name: rc_channel_arbiter

Overview:
- Collects width results from NUM_CH independent RC pulse-width detectors and funnels them into one valid/ready stream tagged with a channel index.
- Sits between the per-channel detectors and the downstream consumer (servo mixer / register bank).
- Round-robin arbitration ensures no channel starves.
- Per-channel stale timeout provides a failsafe indication, and a sticky overrun flag marks results dropped before they were read.

Parameters:
- NUM_CH, 4, number of detector channels (2..8).
- CH_W, 2, width of channel index; must satisfy 2^CH_W >= NUM_CH.
- WIDTH, 16, width of each pulse-width result.
- TIMEOUT_CYC, 2000000, cycles without an update before a channel is declared stale.
- TO_W, 21, width of each timeout counter; must hold TIMEOUT_CYC.

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_width  in  NUM_CH*WIDTH  concatenated detector results; channel c occupies bits [c*WIDTH +: WIDTH].
- i_strobe  in  NUM_CH  one-cycle pulse per channel; the matching i_width slice is valid in that cycle.
- o_valid  out  1  output word available.
- i_ready  in  1  consumer accepts the word when o_valid && i_ready at a rising edge.
- o_data  out  WIDTH  granted width value.
- o_ch  out  CH_W  channel index of o_data.
- o_stale  out  NUM_CH  1 = no strobe from that channel for >= TIMEOUT_CYC cycles.
- o_overrun  out  NUM_CH  sticky: a pending value was overwritten before it was granted.
- i_clr_overrun  in  1  clears all o_overrun bits.

Behaviour:
- Reset (i_rst_n=0 at an edge):
  - pending=0, hold regs=0, o_valid=0, o_data=0, o_ch=0, o_overrun=0.
  - Round-robin pointer set so channel 0 has highest priority next.
  - All timeout counters loaded to TIMEOUT_CYC, so o_stale = all ones.
  - Reset dominates every other input in the same cycle. A mid-transfer reset discards the word; no handshake is completed.
- Capture, per channel c, when i_strobe[c]=1:
  - hold[c] <= i_width slice; pending[c] <= 1.
  - If pending[c] was already 1 and channel c is not being granted this cycle, o_overrun[c] <= 1; newest value wins.
- Output register:
  - "Free" means o_valid=0, or o_valid=1 with i_ready=1 (word consumed this edge).
  - When free and any pending bit is set: select the first pending channel searching from last_grant+1 upward, wrapping at NUM_CH-1 to 0.
  - On selection: o_data <= hold[sel], o_ch <= sel, o_valid <= 1, pending[sel] <= 0, last_grant <= sel.
  - When free and none pending: o_valid <= 0.
  - While o_valid && !i_ready, o_data and o_ch are held stable and no grant occurs.
- Same-cycle grant and strobe on channel sel:
  - Output takes the old hold value.
  - hold[sel] takes the new value and pending[sel] stays 1.
  - No overrun is flagged.
- Latency and throughput:
  - Strobe at edge k with the output free and no other pending channel gives o_valid=1 after edge k+1.
  - Back-to-back throughput is one word per cycle when i_ready=1.
- Data is passed unmodified. 16'hFFFF (too-long code) and 0 (no-signal code) are ordinary values.
- Stale timeout, per channel:
  - Strobe clears the counter to 0 and o_stale[c] to 0 on the same edge.
  - Otherwise the counter increments and saturates at TIMEOUT_CYC.
  - o_stale[c] = (counter == TIMEOUT_CYC), registered.
- Overrun clearing:
  - i_clr_overrun=1 clears all bits.
  - A new overrun event in the same cycle wins (bit ends set).
- The output is purely registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then idle, with TIMEOUT_CYC=100 for sim: o_valid=0, o_data=0, o_stale=4'b1111. Strobe ch2 with width 1500 at edge k: o_stale[2]=0 after k, o_valid=1, o_ch=2, o_data=1500 after k+1.
- Strobe ch0..ch3 simultaneously (1000, 1100, 1200, 1300) with i_ready=1: words emitted on consecutive cycles in order ch0, ch1, ch2, ch3. Then strobe ch0 and ch3 together: ch0 is granted first (pointer after 3 wraps to 0).
- i_ready=0, strobe ch1=1200 then ch1=1250 two cycles later: first word held stable at 1200. Raise i_ready: 1200 is accepted, then 1250 is emitted. Repeat with ch1 strobed twice before any grant: o_overrun[1]=1, only the latest value is emitted. i_clr_overrun clears the flag.
- Strobe ch0 in the exact cycle ch0 is granted: the granted word carries the old value, the next word carries the new value, o_overrun[0]=0.
- No strobes on ch3 for 100 cycles (TIMEOUT_CYC=100): o_stale[3] rises on exactly the 100th cycle and stays 1. One strobe drops it to 0 and the count restarts.
- Assert i_rst_n=0 while o_valid=1 and i_ready=0 with pending ch1/ch2: the next cycle shows all outputs at reset values. After release with no new strobes, o_valid stays 0.

Source files
------------

// File: rtl/rc_channel_arbiter_if.sv
// Valid/ready result stream carrying one pulse-width word tagged with its channel index.
interface rc_channel_arbiter_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CH_W  = 2
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic [CH_W-1:0]  ch;

    modport master (output valid, output data, output ch, input ready);
    modport slave  (input valid, input data, input ch, output ready);
endinterface

// File: rtl/rc_channel_arbiter.sv
// Round-robin funnel of per-channel RC pulse-width results into one tagged stream,
// with per-channel stale timeout and sticky overrun flags.
module rc_channel_arbiter #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CH_W        = 2,
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned TIMEOUT_CYC = 2000000,
    parameter int unsigned TO_W        = 21
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_CH*WIDTH-1:0] i_width,
    input  logic [NUM_CH-1:0]       i_strobe,
    rc_channel_arbiter_if.master    stream,
    output logic [NUM_CH-1:0]       o_stale,
    output logic [NUM_CH-1:0]       o_overrun,
    input  logic                    i_clr_overrun
);

    localparam int unsigned     IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYC);
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    logic [WIDTH-1:0]  hold [NUM_CH];
    logic [TO_W-1:0]   to_cnt [NUM_CH];
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] stale;
    logic [NUM_CH-1:0] overrun;
    logic [CH_W-1:0]   last_grant;
    logic              valid_q;
    logic [WIDTH-1:0]  data_q;
    logic [CH_W-1:0]   ch_q;

    logic              free_c;
    logic              any_c;
    logic              grant_c;
    logic [CH_W-1:0]   sel_c;
    logic [NUM_CH-1:0] gnt_c;

    // First pending channel after last_grant; descending scan leaves the nearest one in sel_c.
    always_comb begin
        sel_c = '0;
        any_c = 1'b0;
        for (int k = int'(NUM_CH); k > 0; k--) begin
            if (pending[IDX_W'((32'(last_grant) + 32'(k)) % NUM_CH)]) begin
                sel_c = CH_W'((32'(last_grant) + 32'(k)) % NUM_CH);
                any_c = 1'b1;
            end
        end
        free_c  = !valid_q || stream.ready;
        grant_c = free_c && any_c;
        gnt_c   = grant_c ? (NUM_CH'(1) << sel_c) : '0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            ch_q       <= '0;
            last_grant <= LAST_CH;
            pending    <= '0;
            overrun    <= '0;
            stale      <= '1;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                hold[c]   <= '0;
                to_cnt[c] <= TO_MAX;
            end
        end else begin
            if (grant_c) begin
                valid_q    <= 1'b1;
                data_q     <= hold[sel_c];
                ch_q       <= sel_c;
                last_grant <= sel_c;
            end else if (free_c) begin
                valid_q <= 1'b0;
            end

            // A strobe on the channel being granted re-arms pending with the new value.
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (i_strobe[c]) begin
                    hold[c]    <= i_width[c*WIDTH +: WIDTH];
                    pending[c] <= 1'b1;
                    to_cnt[c]  <= '0;
                    stale[c]   <= 1'b0;
                end else begin
                    if (gnt_c[c]) begin
                        pending[c] <= 1'b0;
                    end
                    if (to_cnt[c] != TO_MAX) begin
                        to_cnt[c] <= to_cnt[c] + TO_W'(1);
                        stale[c]  <= (to_cnt[c] + TO_W'(1)) == TO_MAX;
                    end
                end
            end

            // New overrun events win over a same-cycle clear.
            overrun <= (i_clr_overrun ? '0 : overrun) | (i_strobe & pending & ~gnt_c);
        end
    end

    assign stream.valid = valid_q;
    assign stream.data  = data_q;
    assign stream.ch    = ch_q;
    assign o_stale      = stale;
    assign o_overrun    = overrun;

endmodule

// File: tb/tb_rc_channel_arbiter.sv
// Directed bench for rc_channel_arbiter with a shortened stale timeout.
module tb_rc_channel_arbiter;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned TO_CYC = 100;
    localparam int unsigned TO_W   = 7;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_CH*WIDTH-1:0] width;
    logic [NUM_CH-1:0]       strobe;
    logic [NUM_CH-1:0]       stale;
    logic [NUM_CH-1:0]       overrun;
    logic                    clr;

    int checks = 0;
    int errors = 0;

    rc_channel_arbiter_if #(.WIDTH(WIDTH), .CH_W(CH_W)) sif ();

    rc_channel_arbiter #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .WIDTH(WIDTH), .TIMEOUT_CYC(TO_CYC), .TO_W(TO_W)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_width       (width),
        .i_strobe      (strobe),
        .stream        (sif),
        .o_stale       (stale),
        .o_overrun     (overrun),
        .i_clr_overrun (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are settled and inputs may change when this returns.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int ch, input logic [WIDTH-1:0] v);
        width[ch*WIDTH +: WIDTH] = v;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        strobe = 4'b1111;
        tick();
        tick();
        checks++; if (sif.valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", sif.valid); end
        checks++; if (sif.data !== 16'd0) begin errors++; $display("FAIL rst_data got %0d exp 0", sif.data); end
        checks++; if (sif.ch !== 2'd0) begin errors++; $display("FAIL rst_ch got %0d exp 0", sif.ch); end
        checks++; if (stale !== 4'b1111) begin errors++; $display("FAIL rst_stale got %b exp 1111", stale); end
        checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL rst_overrun got %b exp 0000", overrun); end
        strobe = 4'b0000;
        rst_n  = 1'b1;
        tick();
        tick();
        checks++; if (sif.valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %0b exp 0", sif.valid); end
        checks++; if (stale !== 4'b1111) begin errors++; $display("FAIL idle_stale got %b exp 1111", stale); end
    endtask

    task automatic test_first_word();
        sif.ready = 1'b0;
        set_w(2, 16'd1500);
        strobe = 4'b0100;
        tick();
        strobe = 4'b0000;
        checks++; if (stale !== 4'b1011) begin errors++; $display("FAIL first_stale got %b exp 1011", stale); end
        checks++; if (sif.valid !== 1'b0) begin errors++; $display("FAIL first_lat_valid got %0b exp 0", sif.valid); end
        tick();
        checks++; if (sif.valid !== 1'b1 || sif.ch !== 2'd2 || sif.data !== 16'd1500) begin
            errors++; $display("FAIL first_word got v=%0b ch=%0d d=%0d exp v=1 ch=2 d=1500", sif.valid, sif.ch, sif.data); end
        sif.ready = 1'b1;
        tick();
        checks++; if (sif.valid !== 1'b0) begin errors++; $display("FAIL first_drain got %0b exp 0", sif.valid); end
    endtask

    task automatic test_round_robin();
        logic [WIDTH-1:0] exp_d [4];
        exp_d[0] = 16'd1000; exp_d[1] = 16'd1100; exp_d[2] = 16'd1200; exp_d[3] = 16'd1300;
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        sif.ready = 1'b1;
        for (int i = 0; i < 4; i++) set_w(i, exp_d[i]);
        strobe = 4'b1111;
        tick();
        strobe = 4'b0000;
        checks++; if (sif.valid !== 1'b0) begin errors++; $display("FAIL rr_lat got %0b exp 0", sif.valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (sif.valid !== 1'b1 || sif.ch !== CH_W'(i) || sif.data !== exp_d[i]) begin
                errors++; $display("FAIL rr_word%0d got v=%0b ch=%0d d=%0d exp v=1 ch=%0d d=%0d", i, sif.valid, sif.ch, sif.data, i, exp_d[i]); end
        end
        tick();
        checks++; if (sif.valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %0b exp 0", sif.valid); end
        set_w(0, 16'd700);
        set_w(3, 16'd730);
        strobe = 4'b1001;
        tick();
        strobe = 4'b0000;
        tick();
        checks++; if (sif.ch !== 2'd0 || sif.data !== 16'd700) begin
            errors++; $display("FAIL rr_wrap0 got ch=%0d d=%0d exp ch=0 d=700", sif.ch, sif.data); end
        tick();
        checks++; if (sif.ch !== 2'd3 || sif.data !== 16'd730) begin
            errors++; $display("FAIL rr_wrap3 got ch=%0d d=%0d exp ch=3 d=730", sif.ch, sif.data); end
        tick();
        checks++; if (sif.valid !== 1'b0) begin errors++; $display("FAIL rr_wrap_drain got %0b exp 0", sif.valid); end
    endtask

    task automatic test_backpressure();
        sif.ready = 1'b0;
        set_w(1, 16'd1200);
        strobe = 4'b0010;
        tick();
        strobe = 4'b0000;
        tick();
        checks++; if (sif.valid !== 1'b1 || sif.ch !== 2'd1 || sif.data !== 16'd1200) begin
            errors++; $display("FAIL bp_first got v=%0b ch=%0d d=%0d exp v=1 ch=1 d=1200", sif.valid, sif.ch, sif.data); end
        set_w(1, 16'd1250);
        strobe = 4'b0010;
        tick();
        strobe = 4'b0000;
        checks++; if (sif.valid !== 1'b1 || sif.data !== 16'd1200) begin
            errors++; $display("FAIL bp_hold1 got v=%0b d=%0d exp v=1 d=1200", sif.valid, sif.data); end
        tick();
        checks++; if (sif.data !== 16'd1200 || sif.ch !== 2'd1) begin
            errors++; $display("FAIL bp_hold2 got ch=%0d d=%0d exp ch=1 d=1200", sif.ch, sif.data); end
        sif.ready = 1'b1;
        tick();
        checks++; if (sif.valid !== 1'b1 || sif.ch !== 2'd1 || sif.data !== 16'd1250) begin
            errors++; $display("FAIL bp_second got v=%0b ch=%0d d=%0d exp v=1 ch=1 d=1250", sif.valid, sif.ch, sif.data); end
        tick();
        checks++; if (sif.valid !== 1'b0 || overrun !== 4'b0000) begin
            errors++; $display("FAIL bp_drain got v=%0b ovr=%b exp v=0 ovr=0000", sif.valid, overrun); end
    endtask

    task automatic test_overrun();
        sif.ready = 1'b0;
        set_w(0, 16'd900);
        strobe = 4'b0001;
        tick();
        strobe = 4'b0000;
        tick();
        checks++; if (sif.ch !== 2'd0 || sif.data !== 16'd900) begin
            errors++; $display("FAIL ovr_block got ch=%0d d=%0d exp ch=0 d=900", sif.ch, sif.data); end
        set_w(1, 16'd1300);
        strobe = 4'b0010;
        tick();
        checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL ovr_none got %b exp 0000", overrun); end
        set_w(1, 16'd1350);
        tick();
        strobe = 4'b0000;
        checks++; if (overrun !== 4'b0010) begin errors++; $display("FAIL ovr_set got %b exp 0010", overrun); end
        sif.ready = 1'b1;
        tick();
        checks++; if (sif.valid !== 1'b1 || sif.ch !== 2'd1 || sif.data !== 16'd1350) begin
            errors++; $display("FAIL ovr_latest got v=%0b ch=%0d d=%0d exp v=1 ch=1 d=1350", sif.valid, sif.ch, sif.data); end
        tick();
        checks++; if (sif.valid !== 1'b0 || overrun !== 4'b0010) begin
            errors++; $display("FAIL ovr_sticky got v=%0b ovr=%b exp v=0 ovr=0010", sif.valid, overrun); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL ovr_clr got %b exp 0000", overrun); end
        // clear and a fresh overrun on ch3 in the same cycle
        sif.ready = 1'b0;
        set_w(2, 16'd400);
        strobe = 4'b0100;
        tick();
        strobe = 4'b0000;
        tick();
        set_w(3, 16'd10);
        strobe = 4'b1000;
        tick();
        set_w(3, 16'd11);
        clr = 1'b1;
        tick();
        clr    = 1'b0;
        strobe = 4'b0000;
        checks++; if (overrun !== 4'b1000) begin errors++; $display("FAIL ovr_clr_race got %b exp 1000", overrun); end
        sif.ready = 1'b1;
        tick();
        checks++; if (sif.ch !== 2'd3 || sif.data !== 16'd11) begin
            errors++; $display("FAIL ovr_race_data got ch=%0d d=%0d exp ch=3 d=11", sif.ch, sif.data); end
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (overrun !== 4'b0000 || sif.valid !== 1'b0) begin
            errors++; $display("FAIL ovr_clr2 got ovr=%b v=%0b exp ovr=0000 v=0", overrun, sif.valid); end
    endtask

    task automatic test_same_cycle_grant();
        sif.ready = 1'b1;
        set_w(0, 16'd500);
        strobe = 4'b0001;
        tick();
        checks++; if (sif.valid !== 1'b0) begin errors++; $display("FAIL sc_lat got %0b exp 0", sif.valid); end
        set_w(0, 16'd600);
        tick();
        strobe = 4'b0000;
        checks++; if (sif.valid !== 1'b1 || sif.ch !== 2'd0 || sif.data !== 16'd500) begin
            errors++; $display("FAIL sc_old got v=%0b ch=%0d d=%0d exp v=1 ch=0 d=500", sif.valid, sif.ch, sif.data); end
        tick();
        checks++; if (sif.valid !== 1'b1 || sif.ch !== 2'd0 || sif.data !== 16'd600) begin
            errors++; $display("FAIL sc_new got v=%0b ch=%0d d=%0d exp v=1 ch=0 d=600", sif.valid, sif.ch, sif.data); end
        checks++; if (overrun[0] !== 1'b0) begin errors++; $display("FAIL sc_overrun got %0b exp 0", overrun[0]); end
        tick();
        checks++; if (sif.valid !== 1'b0) begin errors++; $display("FAIL sc_drain got %0b exp 0", sif.valid); end
    endtask

    task automatic test_stale();
        sif.ready = 1'b1;
        set_w(3, 16'd77);
        strobe = 4'b1000;
        tick();
        strobe = 4'b0000;
        checks++; if (stale[3] !== 1'b0) begin errors++; $display("FAIL stale_clear got %0b exp 0", stale[3]); end
        repeat (99) tick();
        checks++; if (stale[3] !== 1'b0) begin errors++; $display("FAIL stale_99 got %0b exp 0", stale[3]); end
        tick();
        checks++; if (stale[3] !== 1'b1) begin errors++; $display("FAIL stale_100 got %0b exp 1", stale[3]); end
        repeat (5) tick();
        checks++; if (stale[3] !== 1'b1) begin errors++; $display("FAIL stale_hold got %0b exp 1", stale[3]); end
        strobe = 4'b1000;
        tick();
        strobe = 4'b0000;
        checks++; if (stale[3] !== 1'b0) begin errors++; $display("FAIL stale_drop got %0b exp 0", stale[3]); end
        tick();
        checks++; if (stale[3] !== 1'b0) begin errors++; $display("FAIL stale_restart got %0b exp 0", stale[3]); end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        sif.ready = 1'b0;
        set_w(1, 16'd2222);
        strobe = 4'b0010;
        tick();
        strobe = 4'b0000;
        tick();
        checks++; if (sif.valid !== 1'b1 || sif.ch !== 2'd1 || sif.data !== 16'd2222) begin
            errors++; $display("FAIL mid_word got v=%0b ch=%0d d=%0d exp v=1 ch=1 d=2222", sif.valid, sif.ch, sif.data); end
        set_w(1, 16'd10);
        set_w(2, 16'd20);
        strobe = 4'b0110;
        tick();
        strobe = 4'b0000;
        rst_n  = 1'b0;
        tick();
        checks++; if (sif.valid !== 1'b0 || sif.data !== 16'd0 || sif.ch !== 2'd0) begin
            errors++; $display("FAIL mid_rst_out got v=%0b ch=%0d d=%0d exp v=0 ch=0 d=0", sif.valid, sif.ch, sif.data); end
        checks++; if (stale !== 4'b1111 || overrun !== 4'b0000) begin
            errors++; $display("FAIL mid_rst_flags got stale=%b ovr=%b exp stale=1111 ovr=0000", stale, overrun); end
        rst_n     = 1'b1;
        sif.ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (sif.valid !== 1'b0) begin errors++; $display("FAIL mid_post%0d got %0b exp 0", i, sif.valid); end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        width     = '0;
        strobe    = '0;
        clr       = 1'b0;
        sif.ready = 1'b0;
        test_reset();
        test_first_word();
        test_round_robin();
        test_backpressure();
        test_overrun();
        test_same_cycle_grant();
        test_stale();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
